// File: rtl/seg7_pkg.sv
// Shared segment constants for the 7-segment scan display (segments g..a, active-low).
// Pure constants: no latency, no flow control.
package seg7_pkg;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Entry n is the glyph for hex value n; the leftmost element is entry 15.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low 7-segment glyph.
// Purely combinational, no flow control.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner; outputs registered 1 cycle after scan state; no backpressure.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_dig;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;

  logic [3:0]              cur_hex;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_lz;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              hex_seg;

  always_comb begin
    cur_hex   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_hex   = sh_dig[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_blank = sh_blank[i];
        an_sel[i] = 1'b0;
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  lz_run;

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run = lz_run & (sh_dig[4*i +: 4] == 4'h0);
      lz[i]  = lz_run;
    end
  end

  always_comb begin
    cur_lz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) cur_lz = lz[i];
    end
  end
`else
  assign cur_lz = 1'b0;
`endif

  seg7_hex_decode u_dec (
    .hex (cur_hex),
    .seg (hex_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc    <= '0;
      idx      <= '0;
      sh_dig   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      seg      <= SEG_DASH;
      dp       <= 1'b1;
      an       <= '1;
    end else begin
      if (load) begin
        sh_dig   <= digits;
        sh_dp    <= dp_in;
        sh_blank <= blank;
      end
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      // Prescaler 0 is dead time between digits so ghosting cannot occur.
      seg <= (cur_blank | cur_lz) ? SEG_OFF : hex_seg;
      dp  <= cur_blank ? 1'b1 : ~cur_dp;
      an  <= (presc == '0) ? '1 : an_sel;
    end
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning number of multiplexed digits (legal range 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit is active (legal range 4..2^20).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset: synchronous and active-low (0 = reset).
REQ-005 SHALL have port load  input  1  meaning a 1-cycle strobe that captures digits, dp_in and blank.
REQ-006 SHALL have port digits  input  4*NUM_DIGITS  meaning hex value per digit, where digit i is bits [4i+3:4i] and digit 0 is rightmost.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  meaning decimal point per digit, active-high.
REQ-008 SHALL have port blank  input  NUM_DIGITS  meaning force digit dark, active-high.
REQ-009 SHALL have port seg  output  7  meaning segments g..a, active-low.
REQ-010 SHALL have port dp  output  1  meaning decimal point, active-low.
REQ-011 SHALL have port an  output  NUM_DIGITS  meaning digit enables, active-low, at most one low.

Function
REQ-012 SHALL hold digits, dp_in and blank in shadow registers updated only on cycles with load=1, so that the display never shows a partial value.
REQ-013 SHALL contain a prescaler counting 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and the digit index advances, with NUM_DIGITS-1 wrapping to 0.
REQ-014 SHALL drive all outputs from registers, with 1-cycle latency from the index/prescaler state to seg/dp/an.
REQ-015 SHALL drive an all-high (dead time) while prescaler==0 and drive an[index]=0 for prescaler 1..SCAN_DIV-1.
REQ-016 SHALL decode all 16 codes, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 SHALL drive seg=1111111 and dp=1 for a digit whose shadow blank bit is 1; an still selects it.
REQ-018 SHALL otherwise drive dp = ~shadow dp_in[index].
REQ-019 SHALL make a load on the same cycle as an index advance affect the digit shown from the next cycle onward; the scan timing SHALL be unaffected.

Reset
REQ-020 SHALL set the following on a clk edge with rst=0: prescaler=0, index=0, shadow digits=0, shadow dp_in=0, shadow blank=0, seg=0111111 (dash), dp=1, an=all-high.
REQ-021 SHALL hold seg=0111111, dp=1 and an=all-high while rst=0, and ignore load.
REQ-022 SHALL abort the scan when reset is asserted mid-scan; after release the scan SHALL restart at index 0, prescaler 0.

Configuration
REQ-023 SHALL provide leading-zero blanking when macro SEG7_LZB_EN is defined: digit i>0 SHALL be blanked when shadow digits i..NUM_DIGITS-1 are all 0; digit 0 is never blanked by this rule; dp SHALL still follow dp_in.
REQ-024 SHALL display zeros normally when SEG7_LZB_EN is undefined, with no LZB logic present.

Structure
REQ-025 SHALL place the segment constants (SEG_DASH=0111111, SEG_OFF=1111111) and the 16-entry decode constants in shared package seg7_pkg.
REQ-026 SHALL implement the decode in combinational sub-module seg7_hex_decode (4-bit in, 7-bit active-low out), instantiated once.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-027 SHALL cover: rst=0 for 3 cycles, then release -> during reset seg=0111111, an=1111; on the first post-reset cycle an=1111 (dead time), then an=1110 for 3 cycles.
REQ-028 SHALL cover: load digits=16'h12AF, dp_in=0100 -> an=1110 seg=0001110; an=1101 seg=0001000; an=1011 seg=0100100 dp=0; an=0111 seg=1111001; the sequence SHALL repeat every 16 cycles.
REQ-029 SHALL cover: change digits without load -> seg sequence unchanged; then pulse load -> new value appears at next digit slot.
REQ-030 SHALL cover: blank=1000 with digits=16'h8888 -> digit 3 slot seg=1111111 dp=1, other slots seg=0000000.
REQ-031 SHALL cover: digits=16'h0050 -> with SEG7_LZB_EN, digit 3 and digit 2 slots show 1111111, digit 1 shows 0010010, digit 0 shows 1000000; without the macro, digits 3 and 2 show 1000000.
REQ-032 SHALL cover: rst=0 asserted at index 2 mid-slot -> next edge seg=0111111, an=1111; after release the scan restarts at digit 0.
